// File: rtl/operand_loader_pkg.sv
// Shared types for the operand loader: FSM state encoding driven onto the LEDs.
package operand_loader_pkg;

  typedef enum logic [1:0] {
    S_WAIT_A = 2'b00,
    S_WAIT_B = 2'b01,
    S_VALID  = 2'b10
  } state_t;

endpackage

// File: rtl/operand_loader_edge_sync.sv
// Two-flop synchronizer plus rising-edge detector for the asynchronous load button.
module edge_sync (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic async_i,
  output logic pulse_o
);

  logic s1_q;
  logic s2_q;
  logic prev_q;

  // Flops reset high so a button held through reset release never looks like a fresh edge.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      s1_q   <= 1'b1;
      s2_q   <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      s1_q   <= async_i;
      s2_q   <= s1_q;
      prev_q <= s2_q;
    end
  end

  assign pulse_o = s2_q & ~prev_q;

endmodule

// File: rtl/operand_loader.sv
// Captures operand A then B on successive button presses and offers the pair downstream.
module operand_loader
  import operand_loader_pkg::*;
#(
  parameter int N     = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic [N-1:0]     data_i,
  input  logic             load_i,
  input  logic             clear_i,
  input  logic             ready_i,
  output logic [N-1:0]     a_o,
  output logic [N-1:0]     b_o,
  output logic             valid_o,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] count_o
);

  // Handshake: a transfer happens on any rising edge where valid_o and ready_i are both
  // high; valid_o is registered and holds (with a_o/b_o frozen) until that edge.

  state_t           state_q, state_d;
  logic [N-1:0]     a_q, a_d;
  logic [N-1:0]     b_q, b_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             load_pulse;
  logic             fire;

  edge_sync u_edge_sync (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .async_i (load_i),
    .pulse_o (load_pulse)
  );

  assign fire = valid_q & ready_i;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    valid_d = valid_q;
    count_d = count_q;

    // A transfer coinciding with clear still counts; the clear then wipes the rest.
    if (fire) begin
      count_d = count_q + 1'b1;
    end

    if (clear_i) begin
      a_d     = '0;
      b_d     = '0;
      valid_d = 1'b0;
      state_d = S_WAIT_A;
    end else begin
      case (state_q)
        S_WAIT_A: begin
          valid_d = 1'b0;
          if (load_pulse) begin
            a_d     = data_i;
            state_d = S_WAIT_B;
          end
        end
        S_WAIT_B: begin
          if (load_pulse) begin
            b_d     = data_i;
            valid_d = 1'b1;
            state_d = S_VALID;
          end
        end
        S_VALID: begin
          // Presses here are dropped; operands stay frozen until consumed.
          if (fire) begin
            valid_d = 1'b0;
            state_d = S_WAIT_A;
          end
        end
        default: begin
          valid_d = 1'b0;
          state_d = S_WAIT_A;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= S_WAIT_A;
      a_q     <= '0;
      b_q     <= '0;
      valid_q <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      valid_q <= valid_d;
      count_q <= count_d;
    end
  end

  assign a_o     = a_q;
  assign b_o     = b_q;
  assign valid_o = valid_q;
  assign state_o = state_q;
  assign count_o = count_q;

endmodule

// File: tb/tb_operand_loader.sv
// Directed bench for operand_loader with N=4, CNT_W=2.
module tb_operand_loader;

  logic       clk;
  logic       rst_n_i;
  logic [3:0] data_i;
  logic       load_i;
  logic       clear_i;
  logic       ready_i;
  logic [3:0] a_o;
  logic [3:0] b_o;
  logic       valid_o;
  logic [1:0] state_o;
  logic [1:0] count_o;

  int n_checks;
  int n_fail;
  logic [3:0] sum;

  operand_loader #(.N(4), .CNT_W(2)) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n_i),
    .data_i  (data_i),
    .load_i  (load_i),
    .clear_i (clear_i),
    .ready_i (ready_i),
    .a_o     (a_o),
    .b_o     (b_o),
    .valid_o (valid_o),
    .state_o (state_o),
    .count_o (count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [3:0] d);
    data_i = d;
    load_i = 1'b1;
    tick(4);
    load_i = 1'b0;
    tick(4);
  endtask

  task automatic pulse_ready;
    ready_i = 1'b1;
    tick(1);
    ready_i = 1'b0;
  endtask

  task automatic hard_reset;
    rst_n_i = 1'b0;
    tick(2);
    rst_n_i = 1'b1;
    tick(2);
  endtask

  task automatic test_reset;
    press(4'b1010);
    @(posedge clk);
    #3;
    rst_n_i = 1'b0;
    #1;
    n_checks++; if (a_o !== 4'b0000) begin n_fail++; $display("FAIL reset_a: got %b expected 0000", a_o); end
    n_checks++; if (b_o !== 4'b0000) begin n_fail++; $display("FAIL reset_b: got %b expected 0000", b_o); end
    n_checks++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", valid_o); end
    n_checks++; if (state_o !== 2'b00) begin n_fail++; $display("FAIL reset_state: got %b expected 00", state_o); end
    n_checks++; if (count_o !== 2'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", count_o); end
    tick(2);
    rst_n_i = 1'b1;
    tick(2);
  endtask

  task automatic test_load_sequence;
    press(4'b0101);
    n_checks++; if (a_o !== 4'b0101) begin n_fail++; $display("FAIL load_a_first: got %b expected 0101", a_o); end
    n_checks++; if (state_o !== 2'b01) begin n_fail++; $display("FAIL load_state_wait_b: got %b expected 01", state_o); end
    n_checks++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL load_valid_early: got %b expected 0", valid_o); end
    press(4'b0100);
    n_checks++; if (a_o !== 4'b0101) begin n_fail++; $display("FAIL load_a: got %b expected 0101", a_o); end
    n_checks++; if (b_o !== 4'b0100) begin n_fail++; $display("FAIL load_b: got %b expected 0100", b_o); end
    n_checks++; if (valid_o !== 1'b1) begin n_fail++; $display("FAIL load_valid: got %b expected 1", valid_o); end
    n_checks++; if (state_o !== 2'b10) begin n_fail++; $display("FAIL load_state_valid: got %b expected 10", state_o); end
    sum = a_o + b_o;
    n_checks++; if (sum !== 4'b1001) begin n_fail++; $display("FAIL load_sum: got %b expected 1001", sum); end
  endtask

  task automatic test_backpressure;
    ready_i = 1'b0;
    tick(10);
    press(4'b1111);
    n_checks++; if (a_o !== 4'b0101) begin n_fail++; $display("FAIL bp_a_frozen: got %b expected 0101", a_o); end
    n_checks++; if (b_o !== 4'b0100) begin n_fail++; $display("FAIL bp_b_frozen: got %b expected 0100", b_o); end
    n_checks++; if (valid_o !== 1'b1) begin n_fail++; $display("FAIL bp_valid_held: got %b expected 1", valid_o); end
    n_checks++; if (count_o !== 2'd0) begin n_fail++; $display("FAIL bp_count_held: got %0d expected 0", count_o); end
    pulse_ready();
    n_checks++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL bp_valid_drop: got %b expected 0", valid_o); end
    n_checks++; if (state_o !== 2'b00) begin n_fail++; $display("FAIL bp_state: got %b expected 00", state_o); end
    n_checks++; if (count_o !== 2'd1) begin n_fail++; $display("FAIL bp_count: got %0d expected 1", count_o); end
    n_checks++; if (a_o !== 4'b0101) begin n_fail++; $display("FAIL bp_a_kept: got %b expected 0101", a_o); end
    // ready high before any pair exists must not count
    ready_i = 1'b1;
    tick(3);
    n_checks++; if (count_o !== 2'd1) begin n_fail++; $display("FAIL early_ready_count: got %0d expected 1", count_o); end
    ready_i = 1'b0;
  endtask

  task automatic test_reset_release;
    data_i = 4'b0011;
    load_i = 1'b1;
    rst_n_i = 1'b0;
    tick(2);
    rst_n_i = 1'b1;
    tick(6);
    n_checks++; if (state_o !== 2'b00) begin n_fail++; $display("FAIL held_state: got %b expected 00", state_o); end
    n_checks++; if (a_o !== 4'b0000) begin n_fail++; $display("FAIL held_a: got %b expected 0000", a_o); end
    load_i = 1'b0;
    tick(4);
    press(4'b0011);
    n_checks++; if (a_o !== 4'b0011) begin n_fail++; $display("FAIL rerelease_a: got %b expected 0011", a_o); end
    n_checks++; if (state_o !== 2'b01) begin n_fail++; $display("FAIL rerelease_state: got %b expected 01", state_o); end
  endtask

  task automatic test_clear;
    clear_i = 1'b1;
    tick(1);
    clear_i = 1'b0;
    press(4'b1111);
    n_checks++; if (a_o !== 4'b1111) begin n_fail++; $display("FAIL clr_a_loaded: got %b expected 1111", a_o); end
    clear_i = 1'b1;
    tick(1);
    clear_i = 1'b0;
    n_checks++; if (a_o !== 4'b0000) begin n_fail++; $display("FAIL clr_a: got %b expected 0000", a_o); end
    n_checks++; if (state_o !== 2'b00) begin n_fail++; $display("FAIL clr_state: got %b expected 00", state_o); end
    // clear landing on the same edge as the capture wins
    data_i = 4'b0110;
    load_i = 1'b1;
    tick(2);
    clear_i = 1'b1;
    tick(1);
    clear_i = 1'b0;
    n_checks++; if (a_o !== 4'b0000) begin n_fail++; $display("FAIL clr_vs_load_a: got %b expected 0000", a_o); end
    n_checks++; if (state_o !== 2'b00) begin n_fail++; $display("FAIL clr_vs_load_state: got %b expected 00", state_o); end
    tick(3);
    n_checks++; if (state_o !== 2'b00) begin n_fail++; $display("FAIL clr_no_late_load: got %b expected 00", state_o); end
    load_i = 1'b0;
    tick(4);
    press(4'b1111);
    press(4'b1111);
    n_checks++; if (valid_o !== 1'b1) begin n_fail++; $display("FAIL clr_reload_valid: got %b expected 1", valid_o); end
    sum = a_o + b_o;
    n_checks++; if (sum !== 4'b1110) begin n_fail++; $display("FAIL clr_sum: got %b expected 1110", sum); end
  endtask

  task automatic test_counter_wrap;
    logic [1:0] exp_cnt [4];
    exp_cnt[0] = 2'd1; exp_cnt[1] = 2'd2; exp_cnt[2] = 2'd3; exp_cnt[3] = 2'd0;
    hard_reset();
    for (int i = 0; i < 4; i++) begin
      press(4'(i + 1));
      press(4'(i + 7));
      pulse_ready();
      n_checks++; if (count_o !== exp_cnt[i]) begin n_fail++; $display("FAIL wrap_count_%0d: got %0d expected %0d", i, count_o, exp_cnt[i]); end
    end
    press(4'b0001);
    press(4'b0010);
    ready_i = 1'b1;
    clear_i = 1'b1;
    tick(1);
    ready_i = 1'b0;
    clear_i = 1'b0;
    n_checks++; if (count_o !== 2'd1) begin n_fail++; $display("FAIL clr_fire_count: got %0d expected 1", count_o); end
    n_checks++; if (state_o !== 2'b00) begin n_fail++; $display("FAIL clr_fire_state: got %b expected 00", state_o); end
    n_checks++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL clr_fire_valid: got %b expected 0", valid_o); end
    n_checks++; if (b_o !== 4'b0000) begin n_fail++; $display("FAIL clr_fire_b: got %b expected 0000", b_o); end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n_i  = 1'b0;
    data_i   = 4'b0000;
    load_i   = 1'b0;
    clear_i  = 1'b0;
    ready_i  = 1'b0;
    tick(3);
    rst_n_i = 1'b1;
    tick(2);
    test_reset();
    test_load_sequence();
    test_backpressure();
    test_reset_release();
    test_clear();
    test_counter_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
